// File: rtl/draw_unit.sv
`default_nettype none
// ============================================================================
// Module      : draw_unit
// Description : Command-driven pixel painter. A command FIFO feeds a
//               two-state draw engine that writes an 80x60 3-bit framebuffer.
//               A VGA timing generator scans the framebuffer out with every
//               stored pixel shown as an 8x8 block.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_unit #(
  parameter int FIFO_DEPTH = 16,
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_clk,
  input  logic        we,
  input  logic [15:0] data,
  output logic        full,
  output logic [2:0]  color,
  output logic        hsync,
  output logic        vsync
);

  localparam int c_h_total  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int c_v_total  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int c_hw       = $clog2(c_h_total);
  localparam int c_vw       = $clog2(c_v_total);
  localparam int c_hs_start = H_VIS + H_FP;
  localparam int c_hs_end   = H_VIS + H_FP + H_SYNC;
  localparam int c_vs_start = V_VIS + V_FP;
  localparam int c_vs_end   = V_VIS + V_FP + V_SYNC;
  localparam int c_pw       = $clog2(FIFO_DEPTH);
  localparam int c_cw       = c_pw + 1;
  localparam int c_fb_w     = 80;
  localparam int c_fb_h     = 60;
  localparam int c_fb_size  = c_fb_w * c_fb_h;
  localparam int c_aw       = $clog2(c_fb_size);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  logic [15:0]     r_fifo [FIFO_DEPTH];
  logic [c_pw-1:0] r_wptr;
  logic [c_pw-1:0] r_rptr;
  logic [c_cw-1:0] r_count;
  logic [c_cw-1:0] w_count_next;
  logic            r_full;
  logic            w_push;
  logic            w_pop;
  state_t          r_state;
  logic [15:0]     r_cmd;

  // Pushes while full are dropped; the engine pops only from IDLE
  assign w_push = we && !r_full;
  assign w_pop  = (r_state == ST_IDLE) && (r_count != '0);

  // Next occupancy: a simultaneous push and pop cancel out
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Storage write at the tail; pointers reset so stale entries are never read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= data;
    end
  end

  // Pointer, occupancy and registered full flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_cw'(FIFO_DEPTH));
    end
  end

  // --------------------------------------------------------------------------
  // Draw engine
  // --------------------------------------------------------------------------
  logic [2:0]      w_cmd_col;
  logic [6:0]      w_cmd_x;
  logic [5:0]      w_cmd_y;
  logic            w_in_range;
  logic [c_aw-1:0] w_wr_addr;
  logic            w_fb_we;

  assign w_cmd_col  = r_cmd[15:13];
  assign w_cmd_x    = r_cmd[12:6];
  assign w_cmd_y    = r_cmd[5:0];
  assign w_in_range = (w_cmd_x < 7'(c_fb_w)) && (w_cmd_y < 6'(c_fb_h));
  assign w_wr_addr  = c_aw'(w_cmd_y) * c_aw'(c_fb_w) + c_aw'(w_cmd_x);
  // Reset in the WRITE cycle aborts the write
  assign w_fb_we    = !reset && (r_state == ST_WRITE) && w_in_range;

  // IDLE pops the head into the command register, WRITE always returns to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cmd   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_cmd   <= r_fifo[r_rptr];
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Framebuffer: one write port, one independent read port (read-old on clash)
  // --------------------------------------------------------------------------
  logic [2:0] r_fb [c_fb_size];

  // Draw-engine write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (w_fb_we) begin
      r_fb[w_wr_addr] <= w_cmd_col;
    end
  end

  // --------------------------------------------------------------------------
  // VGA timing and scan-out
  // --------------------------------------------------------------------------
  logic [c_hw-1:0] r_hcnt;
  logic [c_vw-1:0] r_vcnt;
  logic            w_h_last;
  logic            w_v_last;
  logic            w_visible;
  logic            w_hs_active;
  logic            w_vs_active;
  logic [c_aw-1:0] w_rd_addr;
  logic [2:0]      r_color;
  logic            r_hsync;
  logic            r_vsync;

  assign w_h_last    = (r_hcnt == c_hw'(c_h_total - 1));
  assign w_v_last    = (r_vcnt == c_vw'(c_v_total - 1));
  assign w_visible   = (r_hcnt < c_hw'(H_VIS)) && (r_vcnt < c_vw'(V_VIS));
  assign w_hs_active = (r_hcnt >= c_hw'(c_hs_start)) && (r_hcnt < c_hw'(c_hs_end));
  assign w_vs_active = (r_vcnt >= c_vw'(c_vs_start)) && (r_vcnt < c_vw'(c_vs_end));
  // Address forced to 0 in blanking so the read never leaves the array
  assign w_rd_addr   = w_visible ?
                       (c_aw'(r_vcnt >> 3) * c_aw'(c_fb_w) + c_aw'(r_hcnt >> 3)) : '0;

  // Scan counters advance on pixel ticks only
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (vga_clk) begin
      if (w_h_last) begin
        r_hcnt <= '0;
        r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

  // All three outputs registered together from the same counter snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      r_color <= 3'd0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (vga_clk) begin
      r_color <= w_visible ? r_fb[w_rd_addr] : 3'd0;
      r_hsync <= !w_hs_active;
      r_vsync <= !w_vs_active;
    end
  end

  assign full  = r_full;
  assign color = r_color;
  assign hsync = r_hsync;
  assign vsync = r_vsync;

endmodule
`default_nettype wire

// File: tb/tb_draw_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_unit
// Description : Self-checking bench for draw_unit. A cycle model of the FIFO,
//               draw engine, framebuffer and scan timing pushes expected
//               pixel outputs into a queue; they are popped and compared once
//               the DUT has produced them. Reduced VGA timing keeps frames short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_unit;

  localparam int FIFO_DEPTH = 16;
  localparam int H_VIS  = 96;
  localparam int H_FP   = 8;
  localparam int H_SYNC = 16;
  localparam int H_BP   = 8;
  localparam int V_VIS  = 48;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 4;
  localparam int c_h_total = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int c_frame   = c_h_total * c_v_total;
  localparam int c_bound   = 2 * c_frame + 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vga_clk = 1'b0;
  logic        we = 1'b0;
  logic [15:0] data = 16'd0;
  logic        full;
  logic [2:0]  color;
  logic        hsync;
  logic        vsync;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  draw_unit #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vga_clk(vga_clk),
    .we(we),
    .data(data),
    .full(full),
    .color(color),
    .hsync(hsync),
    .vsync(vsync)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model and scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    logic [2:0] col;
    bit         known;
    logic       hs;
    logic       vs;
    int         h;
    int         v;
  } pix_t;

  pix_t        sb[$];
  pix_t        cur;
  logic [15:0] m_q[$];
  int          m_cnt;
  bit          m_full;
  bit          m_write;
  logic [15:0] m_cmd;
  logic [2:0]  m_fb [4800];
  bit          m_known [4800];
  int          m_h;
  int          m_v;

  always @(posedge clk) begin
    pix_t p;
    int   idx;
    int   x;
    int   y;
    if (reset) begin
      m_cnt = 0; m_full = 0; m_write = 0; m_q.delete();
      m_h = 0; m_v = 0; sb.delete();
      p.col = 3'd0; p.known = 1'b1; p.hs = 1'b1; p.vs = 1'b1; p.h = -1; p.v = -1;
      sb.push_back(p);
    end else begin
      // scan-out expectation uses framebuffer contents before this edge's write
      if (vga_clk) begin
        p.h = m_h; p.v = m_v;
        if (m_h < H_VIS && m_v < V_VIS) begin
          idx = (m_v / 8) * 80 + (m_h / 8);
          p.col = m_fb[idx]; p.known = m_known[idx];
        end else begin
          p.col = 3'd0; p.known = 1'b1;
        end
        p.hs = !(m_h >= H_VIS + H_FP && m_h < H_VIS + H_FP + H_SYNC);
        p.vs = !(m_v >= V_VIS + V_FP && m_v < V_VIS + V_FP + V_SYNC);
        sb.push_back(p);
        m_h++;
        if (m_h == c_h_total) begin
          m_h = 0;
          m_v = (m_v + 1) % c_v_total;
        end
      end
      // draw engine: WRITE then IDLE; IDLE pops when the FIFO held entries
      if (m_write) begin
        x = int'(m_cmd[12:6]); y = int'(m_cmd[5:0]);
        if (x < 80 && y < 60) begin
          m_fb[y * 80 + x] = m_cmd[15:13];
          m_known[y * 80 + x] = 1'b1;
        end
        m_write = 0;
      end else if (m_cnt > 0) begin
        m_cmd = m_q.pop_front();
        m_write = 1;
        m_cnt--;
      end
      if (we && !m_full) begin
        m_q.push_back(data);
        m_cnt++;
      end
      m_full = (m_cnt == FIFO_DEPTH);
    end
    #1;
    while (sb.size() > 0) cur = sb.pop_front();
    check("full", int'(full), int'(m_full));
    check("hsync", int'(hsync), int'(cur.hs));
    check("vsync", int'(vsync), int'(cur.vs));
    if (cur.known) check("color", int'(color), int'(cur.col));
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic push_cmd(input logic [2:0] c, input int x, input int y);
    int n = 0;
    while (full && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("push_wait_timeout", n, 0);
    data = {c, 7'(x), 6'(y)};
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  // sel: 0 colour, 1 hsync, 2 vsync; waits until the output shows pixel (h,v)
  task automatic expect_at(input string tag, input int sel, input int h, input int v,
                           input int val);
    int n = 0;
    while (!(cur.h == h && cur.v == v) && n < c_bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= c_bound) check({tag, "_timeout"}, n, 0);
    else if (sel == 0) check(tag, int'(color), val);
    else if (sel == 1) check(tag, int'(hsync), val);
    else check(tag, int'(vsync), val);
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    int n;
    int hl;
    int vl;

    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_full", int'(full), 0);
    check("rst_color", int'(color), 0);
    check("rst_hsync", int'(hsync), 1);
    check("rst_vsync", int'(vsync), 1);
    reset = 1'b0;
    vga_clk = 1'b1;

    // clear the visible region so every displayed pixel has a known value
    for (int y = 0; y < V_VIS / 8; y++)
      for (int x = 0; x < H_VIS / 8; x++)
        push_cmd(3'd0, x, y);
    repeat (2 * FIFO_DEPTH + 10) @(negedge clk);

    // out-of-range flood: fills the FIFO, then full toggles while draining
    data = 16'hFFFF;
    we = 1'b1;
    n = 0;
    while (!full && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t1_full_rise_cycle", n, 2 * FIFO_DEPTH - 1);
    repeat (40) @(negedge clk);
    we = 1'b0;
    repeat (2 * FIFO_DEPTH + 10) @(negedge clk);
    check("t1_drained_full", int'(full), 0);

    // corner pixels of the visible area
    push_cmd(3'd7, 0, 0);
    push_cmd(3'd1, H_VIS / 8 - 1, V_VIS / 8 - 1);
    repeat (200) @(negedge clk);
    expect_at("t2_origin", 0, 0, 0, 7);
    expect_at("t2_next_block", 0, 8, 0, 0);
    expect_at("t2_hblank", 0, H_VIS, 0, 0);
    expect_at("t2_origin_block_end", 0, 7, 7, 7);
    expect_at("t2_corner_first", 0, H_VIS - 8, V_VIS - 8, 1);
    expect_at("t2_corner_last", 0, H_VIS - 1, V_VIS - 1, 1);
    expect_at("t2_after_corner", 0, H_VIS, V_VIS - 1, 0);
    expect_at("t2_vblank", 0, 0, V_VIS, 0);

    // sync pulse widths over exactly one frame, then pulse boundaries
    expect_at("t3_frame_start_hs", 1, 0, 0, 1);
    hl = 0;
    vl = 0;
    for (int i = 0; i < c_frame; i++) begin
      if (!hsync) hl++;
      if (!vsync) vl++;
      @(negedge clk);
    end
    check("t3_hsync_low_ticks", hl, H_SYNC * c_v_total);
    check("t3_vsync_low_ticks", vl, V_SYNC * c_h_total);
    expect_at("t3_hs_before", 1, H_VIS + H_FP - 1, 0, 1);
    expect_at("t3_hs_first", 1, H_VIS + H_FP, 0, 0);
    expect_at("t3_hs_last", 1, H_VIS + H_FP + H_SYNC - 1, 0, 0);
    expect_at("t3_hs_after", 1, H_VIS + H_FP + H_SYNC, 0, 1);
    expect_at("t3_vs_before", 2, c_h_total - 1, V_VIS + V_FP - 1, 1);
    expect_at("t3_vs_first", 2, 0, V_VIS + V_FP, 0);
    expect_at("t3_vs_last", 2, c_h_total - 1, V_VIS + V_FP + V_SYNC - 1, 0);
    expect_at("t3_vs_after", 2, 0, V_VIS + V_FP + V_SYNC, 1);

    // repeated writes to one pixel: last one wins
    for (int c = 1; c <= 4; c++) push_cmd(3'(c), 10, 5);
    repeat (20) @(negedge clk);
    expect_at("t4_block_first", 0, 80, 40, 4);
    expect_at("t4_block_last", 0, 87, 47, 4);

    // pixel-tick enable held low mid-line inside the hsync pulse
    expect_at("t5_pre", 1, 110, 20, 0);
    vga_clk = 1'b0;
    repeat (100) @(negedge clk);
    check("t5_hold_hsync", int'(hsync), 0);
    check("t5_hold_vsync", int'(vsync), 1);
    check("t5_hold_color", int'(color), 0);
    vga_clk = 1'b1;
    for (int i = 0; i < 300; i++) begin
      vga_clk = 1'(i % 2);
      @(negedge clk);
    end
    vga_clk = 1'b1;

    // reset mid-frame with commands queued and one in flight
    expect_at("t6_pre", 1, 50, 20, 1);
    for (int i = 0; i < 16; i++) begin
      data = {3'd5, 7'(i % 12), 6'(i / 12)};
      we = 1'b1;
      @(negedge clk);
    end
    we = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_full", int'(full), 0);
    check("t6_hsync", int'(hsync), 1);
    check("t6_vsync", int'(vsync), 1);
    check("t6_color", int'(color), 0);
    @(negedge clk);
    check("t6_restart_origin", int'(color), 5);
    expect_at("t6_drawn_x6", 0, 48, 0, 5);
    expect_at("t6_aborted_x7", 0, 56, 0, 0);
    expect_at("t6_queued_dropped", 0, 24, 8, 0);
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
